// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: pointer width and the read-mode selector.
// Pure declarations, no logic, no timing.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_ptr_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// FIFO write/read handshake bundle; master is the producer/consumer side, slave is the FIFO.
// Flags and level travel FIFO -> user; enables and write data travel user -> FIFO.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int BITS = 32,
    parameter int SIZE = 16
);
    localparam int PW = fifo_ptr_w(SIZE);

    logic            wr_en;
    logic [BITS-1:0] wr_data;
    logic            wr_full;
    logic            wr_almost_full;
    logic            rd_en;
    logic [BITS-1:0] rd_data;
    logic            rd_empty;
    logic            rd_almost_empty;
    logic [PW-1:0]   level;
    logic            overflow;
    logic            underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
               level, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// BITS x SIZE register array: synchronous write, asynchronous read, contents never reset.
// Write lands at the rising edge; read data follows rd_addr combinationally; no backpressure.
module fifo_ram #(
    parameter int BITS = 32,
    parameter int SIZE = 16
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [$clog2(SIZE)-1:0] wr_addr,
    input  logic [BITS-1:0]         wr_dat,
    input  logic [$clog2(SIZE)-1:0] rd_addr,
    output logic [BITS-1:0]         rd_dat
);

    logic [BITS-1:0] mem_q [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard (1-cycle registered) or FWFT read, thresholds, level and error pulses.
// Flags lag accepted ops by one cycle; writes when full and reads when empty are dropped and flagged.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         BITS      = 32,
    parameter int         SIZE      = 16,
    parameter fifo_mode_e FWFT      = FIFO_STD,
    parameter int         AF_THRESH = SIZE - 2,
    parameter int         AE_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst,
    sync_fifo_if.slave fif
);

    localparam int PW = fifo_ptr_w(SIZE);
    localparam int AW = PW - 1;

    if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $error("sync_fifo: SIZE must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > SIZE) begin : g_bad_af
        $error("sync_fifo: AF_THRESH must lie in 1..SIZE");
    end
    if (AE_THRESH < 0 || AE_THRESH > SIZE - 1) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH must lie in 0..SIZE-1");
    end

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BITS-1:0] rd_data_q, rd_data_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic [PW-1:0]   level_w;
    logic [BITS-1:0] ram_rd_dat;
    logic            full_w, empty_w, wr_acc, rd_acc;

    // Pointer MSB disambiguates full from empty, so the plain difference is the occupancy.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (level_w == PW'(SIZE));
    assign empty_w = (level_w == '0);
    assign wr_acc  = fif.wr_en && !full_w && !rst;
    assign rd_acc  = fif.rd_en && !empty_w && !rst;

    fifo_ram #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_dat  (fif.wr_data),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_dat  (ram_rd_dat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        overflow_d  = fif.wr_en && full_w;
        underflow_d = fif.rd_en && empty_w;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            rd_data_d = ram_rd_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // FWFT exposes the head entry directly; standard mode shows the last popped word.
    assign fif.rd_data         = (FWFT == FIFO_FWFT) ? ram_rd_dat : rd_data_q;
    assign fif.rd_empty        = empty_w;
    assign fif.wr_full         = full_w;
    assign fif.level           = level_w;
    assign fif.wr_almost_full  = (level_w >= PW'(AF_THRESH));
    assign fif.rd_almost_empty = (level_w <= PW'(AE_THRESH));
    assign fif.overflow        = overflow_q;
    assign fif.underflow       = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-mode and one FWFT instance, SIZE=4, BITS=8.
// Inputs change #1 after a rising edge; outputs are sampled #1 after the following edge.
module tb_sync_fifo;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.BITS(8), .SIZE(4)) if_s ();
    sync_fifo_if #(.BITS(8), .SIZE(4)) if_f ();

    sync_fifo #(
        .BITS(8), .SIZE(4), .FWFT(FIFO_STD), .AF_THRESH(3), .AE_THRESH(1)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .fif (if_s)
    );

    sync_fifo #(
        .BITS(8), .SIZE(4), .FWFT(FIFO_FWFT), .AF_THRESH(3), .AE_THRESH(1)
    ) u_fw (
        .clk (clk),
        .rst (rst),
        .fif (if_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (if_s.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", if_s.level); end
        n_checks++; if (if_s.rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", if_s.rd_empty); end
        n_checks++; if (if_s.wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", if_s.wr_full); end
        n_checks++; if (if_s.rd_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", if_s.rd_almost_empty); end
        n_checks++; if (if_s.wr_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", if_s.wr_almost_full); end
        n_checks++; if (if_s.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", if_s.rd_data); end
        n_checks++; if (if_s.overflow !== 1'b0 || if_s.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got ovf=%b udf=%b want 0 0", if_s.overflow, if_s.underflow); end
        n_checks++; if (if_f.rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty got %b want 1", if_f.rd_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            if_s.wr_en   = 1'b1;
            if_s.wr_data = 8'hA1 + 8'(i);
            tick();
            n_checks++; if (if_s.level !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, if_s.level, i + 1); end
            n_checks++; if (if_s.wr_almost_full !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, if_s.wr_almost_full, (i + 1 >= 3)); end
            n_checks++; if (if_s.wr_full !== (i + 1 == 4)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, if_s.wr_full, (i + 1 == 4)); end
            n_checks++; if (if_s.rd_almost_empty !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, if_s.rd_almost_empty, (i + 1 <= 1)); end
        end
        if_s.wr_en = 1'b0;
    endtask

    task automatic test_overflow_drain();
        if_s.wr_en   = 1'b1;
        if_s.wr_data = 8'hFF;
        tick();
        if_s.wr_en = 1'b0;
        n_checks++; if (if_s.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", if_s.overflow); end
        n_checks++; if (if_s.level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", if_s.level); end
        tick();
        n_checks++; if (if_s.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", if_s.overflow); end
        for (int i = 0; i < 4; i++) begin
            if_s.rd_en = 1'b1;
            tick();
            n_checks++; if (if_s.rd_data !== 8'hA1 + 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, if_s.rd_data, 8'hA1 + 8'(i)); end
        end
        if_s.rd_en = 1'b0;
        n_checks++; if (if_s.rd_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", if_s.rd_empty); end
    endtask

    task automatic test_underflow();
        if_s.rd_en = 1'b1;
        tick();
        if_s.rd_en = 1'b0;
        n_checks++; if (if_s.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got %b want 1", if_s.underflow); end
        n_checks++; if (if_s.rd_data !== 8'hA4) begin n_fail++; $display("FAIL udf_hold got %h want a4", if_s.rd_data); end
        tick();
        n_checks++; if (if_s.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clear got %b want 0", if_s.underflow); end
        if_s.wr_en   = 1'b1;
        if_s.rd_en   = 1'b1;
        if_s.wr_data = 8'h33;
        tick();
        if_s.wr_en = 1'b0;
        if_s.rd_en = 1'b0;
        n_checks++; if (if_s.level !== 3'd1) begin n_fail++; $display("FAIL wr_rd_empty_level got %0d want 1", if_s.level); end
        n_checks++; if (if_s.rd_data !== 8'hA4) begin n_fail++; $display("FAIL wr_rd_empty_data got %h want a4", if_s.rd_data); end
        n_checks++; if (if_s.underflow !== 1'b1) begin n_fail++; $display("FAIL wr_rd_empty_udf got %b want 1", if_s.underflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        exp_q = '{8'h33, 8'h34};
        if_s.wr_en   = 1'b1;
        if_s.wr_data = 8'h34;
        tick();
        n_checks++; if (if_s.level !== 3'd2) begin n_fail++; $display("FAIL b2b_start_level got %0d want 2", if_s.level); end
        if_s.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_s.wr_data = 8'h10 + 8'(i);
            tick();
            exp = exp_q.pop_front();
            exp_q.push_back(8'h10 + 8'(i));
            n_checks++; if (if_s.rd_data !== exp) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, if_s.rd_data, exp); end
            n_checks++; if (if_s.level !== 3'd2) begin n_fail++; $display("FAIL b2b_level[%0d] got %0d want 2", i, if_s.level); end
        end
        if_s.wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            n_checks++; if (if_s.rd_data !== exp) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h want %h", i, if_s.rd_data, exp); end
        end
        if_s.rd_en = 1'b0;
        n_checks++; if (if_s.rd_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", if_s.rd_empty); end
    endtask

    task automatic test_fwft();
        if_f.wr_en   = 1'b1;
        if_f.wr_data = 8'h5C;
        tick();
        if_f.wr_en = 1'b0;
        n_checks++; if (if_f.rd_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_not_empty got %b want 0", if_f.rd_empty); end
        n_checks++; if (if_f.rd_data !== 8'h5C) begin n_fail++; $display("FAIL fwft_data got %h want 5c", if_f.rd_data); end
        tick();
        n_checks++; if (if_f.rd_data !== 8'h5C || if_f.level !== 3'd1) begin n_fail++; $display("FAIL fwft_hold got %h/%0d want 5c/1", if_f.rd_data, if_f.level); end
        if_f.rd_en = 1'b1;
        tick();
        if_f.rd_en = 1'b0;
        n_checks++; if (if_f.rd_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty got %b want 1", if_f.rd_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            if_s.wr_en   = 1'b1;
            if_s.wr_data = 8'h71 + 8'(i);
            tick();
        end
        n_checks++; if (if_s.level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", if_s.level); end
        rst          = 1'b1;
        if_s.wr_data = 8'hEE;
        tick();
        n_checks++; if (if_s.level !== 3'd0 || if_s.rd_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_state got %0d/%b want 0/1", if_s.level, if_s.rd_empty); end
        n_checks++; if (if_s.overflow !== 1'b0 || if_s.underflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got ovf=%b udf=%b want 0 0", if_s.overflow, if_s.underflow); end
        if_s.rd_en = 1'b1;
        tick();
        if_s.wr_en = 1'b0;
        if_s.rd_en = 1'b0;
        rst        = 1'b0;
        n_checks++; if (if_s.underflow !== 1'b0 || if_s.level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_gate got udf=%b lvl=%0d want 0 0", if_s.underflow, if_s.level); end
        if_s.wr_en   = 1'b1;
        if_s.wr_data = 8'h99;
        tick();
        if_s.wr_en = 1'b0;
        if_s.rd_en = 1'b1;
        tick();
        if_s.rd_en = 1'b0;
        n_checks++; if (if_s.rd_data !== 8'h99) begin n_fail++; $display("FAIL mid_new_data got %h want 99", if_s.rd_data); end
        n_checks++; if (if_s.rd_empty !== 1'b1) begin n_fail++; $display("FAIL mid_new_empty got %b want 1", if_s.rd_empty); end
    endtask

    initial begin
        if_s.wr_en = 1'b0; if_s.rd_en = 1'b0; if_s.wr_data = '0;
        if_f.wr_en = 1'b0; if_f.rd_en = 1'b0; if_f.wr_data = '0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
